// File: rtl/m68k_bus_responder_pkg.sv
// Shared types and constants for the 68000 bus responder.
package m68k_bus_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        MISS,
        WR_DS,
        RD_REQ,
        WR_REQ,
        ACK_WAIT,
        HOLD,
        RELEASE
    } state_t;

    // Flop depth for the bus strobes and for the 7 MHz bus clock.
    localparam int SIG_SYNC_DEPTH = 2;
    localparam int CLK_SYNC_DEPTH = 3;

    // Width of the c7m edge counters (wait and timeout).
    localparam int CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/m68k_bus_responder_sync_edge.sv
// N-flop synchronizer for one asynchronous input, with edge strobes
// taken from the last two flops of the chain.
module m68k_sync_edge #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [DEPTH-1:0] s;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= {DEPTH{RST_VAL}};
        end else begin
            s <= {s[DEPTH-2:0], d};
        end
    end

    assign q    = s[DEPTH-1];
    assign rise = s[DEPTH-2] & ~s[DEPTH-1];
    assign fall = ~s[DEPTH-2] & s[DEPTH-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: decodes a cycle in the configured window, hands it to a
// req/ack backend port, then answers with data + DTACK, or BERR on timeout.
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int          WIN_BITS    = 16,
    parameter int          MIN_WAIT    = 2,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                PI_CLK,
    input  logic                RESET,
    input  logic                M68K_CLK,
    input  logic                M68K_AS_n,
    input  logic                M68K_UDS_n,
    input  logic                M68K_LDS_n,
    input  logic                M68K_RW,
    input  logic [23:1]         M68K_A,
    input  logic [15:0]         M68K_D_IN,
    output logic [15:0]         M68K_D_OUT,
    output logic                M68K_D_OE,
    output logic                M68K_DTACK_OE,
    output logic                M68K_BERR_OE,
    output logic                BE_REQ,
    output logic                BE_WE,
    output logic [WIN_BITS-2:0] BE_ADDR,
    output logic [1:0]          BE_BYTE_EN,
    output logic [15:0]         BE_WDATA,
    input  logic                BE_ACK,
    input  logic [15:0]         BE_RDATA
);

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             ds_seen;
    logic             hit;
    logic             rw_l;

    logic as_n_s, uds_n_s, lds_n_s, rw_s, c7m_s;
    logic as_rise, as_fall, uds_rise, uds_fall, lds_rise, lds_fall;
    logic rw_rise, rw_fall, c7m_rise, c7m_fall;

    m68k_sync_edge #(.DEPTH(SIG_SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_as (
        .clk(PI_CLK), .rst(RESET), .d(M68K_AS_n),  .q(as_n_s),  .rise(as_rise),  .fall(as_fall));
    m68k_sync_edge #(.DEPTH(SIG_SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_uds (
        .clk(PI_CLK), .rst(RESET), .d(M68K_UDS_n), .q(uds_n_s), .rise(uds_rise), .fall(uds_fall));
    m68k_sync_edge #(.DEPTH(SIG_SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_lds (
        .clk(PI_CLK), .rst(RESET), .d(M68K_LDS_n), .q(lds_n_s), .rise(lds_rise), .fall(lds_fall));
    m68k_sync_edge #(.DEPTH(SIG_SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_rw (
        .clk(PI_CLK), .rst(RESET), .d(M68K_RW),    .q(rw_s),    .rise(rw_rise),  .fall(rw_fall));
    m68k_sync_edge #(.DEPTH(CLK_SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_c7m (
        .clk(PI_CLK), .rst(RESET), .d(M68K_CLK),   .q(c7m_s),   .rise(c7m_rise), .fall(c7m_fall));

    // Strobe edges and the bus-clock level are not needed by this target.
    logic unused_sync;
    assign unused_sync = ^{as_rise, as_fall, uds_rise, uds_fall, lds_rise, lds_fall,
                           rw_rise, rw_fall, c7m_s, c7m_fall};

    // A new cycle is only taken once any earlier backend handshake has closed.
    logic as_start, rd_done, wr_latch;
    assign as_start = (state == IDLE) && !as_n_s && !BE_REQ;
    assign rd_done  = (state == RD_REQ) && BE_ACK && !as_n_s;
    assign wr_latch = (state == WR_DS) && ds_seen && !as_n_s;

    // Bus-cycle sequencing, backend request, and the bus drive enables.
    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            state         <= IDLE;
            BE_REQ        <= 1'b0;
            M68K_D_OE     <= 1'b0;
            M68K_DTACK_OE <= 1'b0;
            M68K_BERR_OE  <= 1'b0;
            wait_cnt      <= '0;
            to_cnt        <= '0;
            ds_seen       <= 1'b0;
        end else begin
            if (BE_REQ && BE_ACK) BE_REQ <= 1'b0;
            if (c7m_rise) wait_cnt <= sat_inc(wait_cnt);
            case (state)
                IDLE: begin
                    if (as_start) begin
                        wait_cnt <= '0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (as_n_s) begin
                        state <= RELEASE;
                    end else if (!hit) begin
                        state <= MISS;
                    end else if (rw_l) begin
                        BE_REQ <= 1'b1;
                        to_cnt <= '0;
                        state  <= RD_REQ;
                    end else begin
                        ds_seen <= 1'b0;
                        state   <= WR_DS;
                    end
                end
                MISS: begin
                    if (as_n_s) state <= IDLE;
                end
                WR_DS: begin
                    if (as_n_s) begin
                        state <= RELEASE;
                    end else if (ds_seen) begin
                        ds_seen <= 1'b0;
                        BE_REQ  <= 1'b1;
                        to_cnt  <= '0;
                        state   <= WR_REQ;
                    end else if (!uds_n_s || !lds_n_s) begin
                        ds_seen <= 1'b1;
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (BE_ACK) begin
                        if (as_n_s) begin
                            state <= RELEASE;
                        end else begin
                            if (state == RD_REQ) M68K_D_OE <= 1'b1;
                            state <= ACK_WAIT;
                        end
                    end else if (as_n_s) begin
                        // Request stays up; IDLE holds off until the ack closes it.
                        state <= RELEASE;
                    end else if (c7m_rise) begin
                        if (sat_inc(to_cnt) >= TO_LIM) begin
                            M68K_BERR_OE <= 1'b1;
                            state        <= HOLD;
                        end else begin
                            to_cnt <= sat_inc(to_cnt);
                        end
                    end
                end
                ACK_WAIT: begin
                    if (as_n_s) begin
                        M68K_D_OE <= 1'b0;
                        state     <= RELEASE;
                    end else if (c7m_rise && (sat_inc(wait_cnt) >= MIN_LIM)) begin
                        M68K_DTACK_OE <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (as_n_s) begin
                        M68K_D_OE     <= 1'b0;
                        M68K_DTACK_OE <= 1'b0;
                        M68K_BERR_OE  <= 1'b0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address/strobe/data capture for the backend port and read data return.
    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            hit        <= 1'b0;
            rw_l       <= 1'b0;
            BE_WE      <= 1'b0;
            BE_ADDR    <= '0;
            BE_BYTE_EN <= 2'b00;
            BE_WDATA   <= 16'h0000;
            M68K_D_OUT <= 16'h0000;
        end else begin
            if (as_start) begin
                BE_ADDR <= M68K_A[WIN_BITS-1:1];
                hit     <= (M68K_A[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS]);
                rw_l    <= rw_s;
            end
            if ((state == DECODE) && hit && rw_l) begin
                BE_WE      <= 1'b0;
                BE_BYTE_EN <= ~{uds_n_s, lds_n_s};
            end
            if (wr_latch) begin
                BE_WE      <= 1'b1;
                BE_BYTE_EN <= ~{uds_n_s, lds_n_s};
                BE_WDATA   <= M68K_D_IN;
            end
            if (rd_done) M68K_D_OUT <= BE_RDATA;
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: read, write, miss, timeout,
// mid-cycle reset and early AS release.
module tb_m68k_bus_responder;

    logic        PI_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        M68K_CLK = 1'b0;
    logic        M68K_AS_n = 1'b1;
    logic        M68K_UDS_n = 1'b1;
    logic        M68K_LDS_n = 1'b1;
    logic        M68K_RW = 1'b1;
    logic [23:1] M68K_A = '0;
    logic [15:0] M68K_D_IN = 16'h0000;
    logic [15:0] M68K_D_OUT;
    logic        M68K_D_OE;
    logic        M68K_DTACK_OE;
    logic        M68K_BERR_OE;
    logic        BE_REQ;
    logic        BE_WE;
    logic [14:0] BE_ADDR;
    logic [1:0]  BE_BYTE_EN;
    logic [15:0] BE_WDATA;
    logic        BE_ACK = 1'b0;
    logic [15:0] BE_RDATA = 16'h0000;

    int checks = 0;
    int errors = 0;
    int c7m_edges = 0;
    bit seen_doe, seen_dtack, seen_berr, seen_req;

    m68k_bus_responder dut (
        .PI_CLK(PI_CLK), .RESET(RESET), .M68K_CLK(M68K_CLK),
        .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n),
        .M68K_RW(M68K_RW), .M68K_A(M68K_A), .M68K_D_IN(M68K_D_IN),
        .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE),
        .M68K_DTACK_OE(M68K_DTACK_OE), .M68K_BERR_OE(M68K_BERR_OE),
        .BE_REQ(BE_REQ), .BE_WE(BE_WE), .BE_ADDR(BE_ADDR),
        .BE_BYTE_EN(BE_BYTE_EN), .BE_WDATA(BE_WDATA),
        .BE_ACK(BE_ACK), .BE_RDATA(BE_RDATA)
    );

    // Pi clock period 10, bus clock period 80 (8 Pi clocks), edges never coincide.
    always #5 PI_CLK = ~PI_CLK;
    always #40 M68K_CLK = ~M68K_CLK;

    always @(posedge M68K_CLK) c7m_edges++;

    // Sticky observation of outputs that must never appear in some windows.
    always @(negedge PI_CLK) begin
        if (M68K_D_OE)     seen_doe = 1'b1;
        if (M68K_DTACK_OE) seen_dtack = 1'b1;
        if (M68K_BERR_OE)  seen_berr = 1'b1;
        if (BE_REQ)        seen_req = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PI_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        seen_doe = 1'b0;
        seen_dtack = 1'b0;
        seen_berr = 1'b0;
        seen_req = 1'b0;
    endtask

    task automatic start_cycle(input logic [23:0] addr, input logic rw,
                               input logic uds_n, input logic lds_n);
        M68K_A     = addr[23:1];
        M68K_RW    = rw;
        M68K_UDS_n = uds_n;
        M68K_LDS_n = lds_n;
        M68K_AS_n  = 1'b0;
    endtask

    task automatic end_cycle();
        M68K_AS_n  = 1'b1;
        M68K_UDS_n = 1'b1;
        M68K_LDS_n = 1'b1;
        M68K_RW    = 1'b1;
    endtask

    task automatic be_ack(input int dly, input logic [15:0] data);
        tick(dly);
        BE_RDATA = data;
        BE_ACK   = 1'b1;
        tick(1);
        BE_ACK   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 60 && !BE_REQ; i++) tick(1);
        chk(tag, 32'(BE_REQ), 32'd1);
    endtask

    task automatic wait_dtack(input string tag);
        for (int i = 0; i < 120 && !M68K_DTACK_OE; i++) tick(1);
        chk(tag, 32'(M68K_DTACK_OE), 32'd1);
    endtask

    initial begin
        clear_seen();
        tick(3);
        // Reset state
        chk("rst_outs", 32'({M68K_D_OE, M68K_DTACK_OE, M68K_BERR_OE, BE_REQ, BE_WE}), 32'd0);
        chk("rst_dout", 32'(M68K_D_OUT), 32'd0);
        RESET = 1'b0;
        tick(4);

        // 1: word read at 0xE80010, ack after 5 clocks with 0xBEEF
        @(posedge M68K_CLK);
        tick(1);
        c7m_edges = 0;
        start_cycle(24'hE80010, 1'b1, 1'b0, 1'b0);
        wait_req("rd_req");
        chk("rd_addr", 32'(BE_ADDR), 32'h0008);
        chk("rd_be", 32'(BE_BYTE_EN), 32'd3);
        chk("rd_we", 32'(BE_WE), 32'd0);
        be_ack(4, 16'hBEEF);
        wait_dtack("rd_dtack");
        chk("rd_dtack_edge", 32'(c7m_edges), 32'd2);
        chk("rd_dout", 32'(M68K_D_OUT), 32'hBEEF);
        chk("rd_doe", 32'(M68K_D_OE), 32'd1);
        end_cycle();
        tick(3);
        chk("rd_release", 32'({M68K_D_OE, M68K_DTACK_OE, M68K_BERR_OE}), 32'd0);
        tick(3);

        // 2: byte write to 0xE80003 on LDS only, data 0x0055
        clear_seen();
        M68K_D_IN = 16'h0055;
        start_cycle(24'hE80003, 1'b0, 1'b1, 1'b1);
        tick(2);
        M68K_LDS_n = 1'b0;
        wait_req("wr_req");
        chk("wr_we", 32'(BE_WE), 32'd1);
        chk("wr_be", 32'(BE_BYTE_EN), 32'd1);
        chk("wr_data", 32'(BE_WDATA), 32'h0055);
        chk("wr_addr", 32'(BE_ADDR), 32'h0001);
        be_ack(2, 16'hFFFF);
        wait_dtack("wr_dtack");
        end_cycle();
        tick(3);
        chk("wr_release", 32'(M68K_DTACK_OE), 32'd0);
        chk("wr_no_doe", 32'(seen_doe), 32'd0);
        tick(3);

        // 3: read outside the window (0xF00000)
        clear_seen();
        start_cycle(24'hF00000, 1'b1, 1'b0, 1'b0);
        tick(40);
        chk("miss_quiet", 32'({seen_req, seen_dtack, seen_berr, seen_doe}), 32'd0);
        end_cycle();
        tick(4);

        // 4: backend never answers, BERR after 64 bus clock edges
        clear_seen();
        start_cycle(24'hE80020, 1'b1, 1'b0, 1'b0);
        wait_req("to_req");
        chk("to_addr", 32'(BE_ADDR), 32'h0010);
        for (int i = 0; i < 800 && !M68K_BERR_OE; i++) tick(1);
        chk("to_berr", 32'(M68K_BERR_OE), 32'd1);
        chk("to_no_dtack", 32'({seen_dtack, seen_doe}), 32'd0);
        chk("to_req_held", 32'(BE_REQ), 32'd1);
        end_cycle();
        tick(3);
        chk("to_berr_off", 32'(M68K_BERR_OE), 32'd0);
        chk("to_req_still", 32'(BE_REQ), 32'd1);
        be_ack(2, 16'h1234);
        chk("to_req_drop", 32'(BE_REQ), 32'd0);
        chk("to_data_drop", 32'(M68K_D_OUT), 32'hBEEF);
        chk("to_no_doe", 32'(M68K_D_OE), 32'd0);
        tick(3);

        // 5: reset while holding DTACK, then a normal read
        start_cycle(24'hE80008, 1'b1, 1'b0, 1'b0);
        wait_req("rs_req");
        be_ack(1, 16'h0F0F);
        wait_dtack("rs_dtack");
        RESET = 1'b1;
        tick(1);
        chk("rs_outs", 32'({M68K_D_OE, M68K_DTACK_OE, M68K_BERR_OE, BE_REQ}), 32'd0);
        chk("rs_dout", 32'(M68K_D_OUT), 32'd0);
        RESET = 1'b0;
        end_cycle();
        tick(4);
        start_cycle(24'hE80004, 1'b1, 1'b0, 1'b0);
        wait_req("rs2_req");
        chk("rs2_addr", 32'(BE_ADDR), 32'h0002);
        be_ack(3, 16'hA5C3);
        wait_dtack("rs2_dtack");
        chk("rs2_dout", 32'(M68K_D_OUT), 32'hA5C3);
        end_cycle();
        tick(3);
        chk("rs2_release", 32'({M68K_D_OE, M68K_DTACK_OE}), 32'd0);
        tick(3);

        // 6: AS released while the read request is outstanding
        clear_seen();
        start_cycle(24'hE80040, 1'b1, 1'b0, 1'b0);
        wait_req("ab_req");
        end_cycle();
        be_ack(10, 16'h7777);
        chk("ab_req_drop", 32'(BE_REQ), 32'd0);
        tick(4);
        chk("ab_quiet", 32'({seen_dtack, seen_doe, seen_berr}), 32'd0);
        chk("ab_dout", 32'(M68K_D_OUT), 32'hA5C3);

        // Follow-up read shows the responder is idle and serving again
        start_cycle(24'hE80002, 1'b1, 1'b1, 1'b0);
        wait_req("ab2_req");
        chk("ab2_be", 32'(BE_BYTE_EN), 32'd1);
        be_ack(2, 16'h1357);
        wait_dtack("ab2_dtack");
        chk("ab2_dout", 32'(M68K_D_OUT), 32'h1357);
        end_cycle();
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
